// File: rtl/zoom_frame_reader_pkg.sv
// Shared display geometry and zoom sizes, plus the window-geometry helper
// used when latching the image size at frame start.
package zoom_frame_reader_pkg;

    localparam int H_ACTIVE_PX = 640;
    localparam int V_ACTIVE_PX = 480;

    localparam int DEFAULT_W  = 160;
    localparam int DEFAULT_H  = 120;
    localparam int ENLARGED_W = 320;
    localparam int ENLARGED_H = 240;
    localparam int REDUCED_W  = 80;
    localparam int REDUCED_H  = 60;

    typedef enum logic {
        WAIT_FRAME,
        RUN
    } state_e;

    // Window corners kept at 11 bits so the raster compares never wrap.
    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] xe;
        logic [10:0] ye;
    } geom_t;

    function automatic geom_t calc_geom(input logic [9:0]  w,
                                        input logic [8:0]  h,
                                        input logic [10:0] h_act,
                                        input logic [10:0] v_act);
        logic [10:0] w11;
        logic [10:0] h11;
        geom_t       g;
        w11 = {1'b0, w};
        h11 = {2'b0, h};
        if (w11 == 11'd0 || h11 == 11'd0 || w11 > h_act || h11 > v_act) begin
            w11 = 11'(DEFAULT_W);
            h11 = 11'(DEFAULT_H);
        end
        g.x0 = (h_act - w11) >> 1;
        g.y0 = (v_act - h11) >> 1;
        g.xe = g.x0 + w11;
        g.ye = g.y0 + h11;
        return g;
    endfunction

endpackage

// File: rtl/zoom_delay_line.sv
// Fixed-depth register delay with asynchronous active-low clear.
module zoom_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/zoom_frame_reader.sv
// Display-side framebuffer reader: centres the latched image window on the
// raster, issues linear reads for in-window pixels and drives border elsewhere.
module zoom_frame_reader
    import zoom_frame_reader_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_PX,
    parameter int V_ACTIVE     = V_ACTIVE_PX,
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 8,
    parameter int MEM_LAT      = 1,
    parameter int BORDER_COLOR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [9:0]        img_width_i,
    input  logic [8:0]        img_height_i,
    input  logic              frame_start_i,
    input  logic              video_on_i,
    input  logic [9:0]        pixel_x_i,
    input  logic [9:0]        pixel_y_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_en_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] pix_out_o,
    output logic              pix_de_o,
    output logic              frame_done_o
);

    localparam int    DLY      = 1 + MEM_LAT;
    localparam geom_t GEOM_RST = calc_geom(10'd0, 9'd0, 11'(H_ACTIVE), 11'(V_ACTIVE));

    state_e            state_q, state_d;
    geom_t             geom_q, geom_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_en_q, done_q, done_d;
    logic              in_win;
    logic [10:0]       px, py;
    logic [1:0]        dly_out;
    logic [DATA_W-1:0] pix_q;
    logic              de_q;

    assign px = {1'b0, pixel_x_i};
    assign py = {1'b0, pixel_y_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= WAIT_FRAME;
            geom_q  <= GEOM_RST;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            geom_q  <= geom_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_en_q <= in_win;
            done_q  <= done_d;
        end
    end

    // The window test always uses the geometry latched before this cycle,
    // so a misplaced frame_start during video reads address 0 with old bounds.
    always_comb begin
        state_d = state_q;
        geom_d  = geom_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        in_win  = (state_q == RUN) && video_on_i &&
                  (px >= geom_q.x0) && (px < geom_q.xe) &&
                  (py >= geom_q.y0) && (py < geom_q.ye);
        if (in_win) begin
            addr_d = frame_start_i ? '0 : cnt_q;
            done_d = (px == geom_q.xe - 11'd1) && (py == geom_q.ye - 11'd1);
        end
        if (frame_start_i) begin
            state_d = RUN;
            geom_d  = calc_geom(img_width_i, img_height_i, 11'(H_ACTIVE), 11'(V_ACTIVE));
            cnt_d   = in_win ? ADDR_W'(1) : '0;
        end else if (in_win && cnt_q != '1) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    zoom_delay_line #(
        .WIDTH(2),
        .DEPTH(DLY)
    ) u_align (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   ({video_on_i, in_win}),
        .q_o   (dly_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q <= DATA_W'(BORDER_COLOR);
            de_q  <= 1'b0;
        end else begin
            pix_q <= dly_out[0] ? mem_data_i : DATA_W'(BORDER_COLOR);
            de_q  <= dly_out[1];
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_rd_en_o  = rd_en_q;
    assign frame_done_o = done_q;
    assign pix_out_o    = pix_q;
    assign pix_de_o     = de_q;

endmodule

// File: tb/tb_zoom_frame_reader.sv
// Bench for zoom_frame_reader: arithmetic window/read-count model with a
// 3-cycle output history, probe points on raster scans, vector table, random frames.
module tb_zoom_frame_reader;
    import zoom_frame_reader_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  img_w = 10'd160;
    logic [8:0]  img_h = 9'd120;
    logic        fs = 1'b0;
    logic        von = 1'b0;
    logic [9:0]  px = '0;
    logic [9:0]  py = '0;
    logic [16:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_data = '0;
    logic [7:0]  pix_out;
    logic        pix_de;
    logic        frame_done;

    always #5 clk = ~clk;

    zoom_frame_reader dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .img_width_i  (img_w),
        .img_height_i (img_h),
        .frame_start_i(fs),
        .video_on_i   (von),
        .pixel_x_i    (px),
        .pixel_y_i    (py),
        .mem_addr_o   (mem_addr),
        .mem_rd_en_o  (mem_rd_en),
        .mem_data_i   (mem_data),
        .pix_out_o    (pix_out),
        .pix_de_o     (pix_de),
        .frame_done_o (frame_done)
    );

    // Framebuffer model: one-cycle latency, returns low address byte.
    always @(posedge clk) if (mem_rd_en) mem_data <= mem_addr[7:0];

    int    tests = 0, fails = 0, seg_bad = 0, rd_cnt = 0, done_cnt = 0;
    string first_bad = "";

    bit m_run;
    int m_w, m_h, m_reads, m_addr;
    int hp[3];
    bit hd[3];

    typedef struct {int x; int y; int rd; int addr; int done; int pix;} probe_t;
    probe_t probes[$];

    typedef struct {bit f; int w; int h; int x; int y; bit v; int rd; int addr; int done;} vec_t;
    vec_t vt[$];

    function automatic void model_reset();
        m_run = 0; m_w = DEFAULT_W; m_h = DEFAULT_H; m_reads = 0; m_addr = 0;
        for (int i = 0; i < 3; i++) begin hp[i] = 0; hd[i] = 0; end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic seg_end(input string name);
        tests++;
        if (seg_bad != 0) begin
            fails++;
            $display("FAIL %s: %0d bad cycles, required 0; first %s", name, seg_bad, first_bad);
        end
        seg_bad = 0;
    endtask

    // One pixel clock: model predicts, DUT is sampled 1 time unit after the edge.
    task automatic cyc(input int x, input int y, input bit v, input bit f);
        int x0, y0, e_pix;
        bit win, e_done;
        px = 10'(x); py = 10'(y); von = v; fs = f;
        if (rst_n) begin
            x0 = (640 - m_w) / 2;
            y0 = (480 - m_h) / 2;
            win = m_run && v && x >= x0 && x < x0 + m_w && y >= y0 && y < y0 + m_h;
            if (win) m_addr = f ? 0 : (m_reads > 131071 ? 131071 : m_reads);
            e_done = win && x == x0 + m_w - 1 && y == y0 + m_h - 1;
            e_pix = win ? m_addr % 256 : 0;
            if (f) begin
                m_run = 1; m_w = int'(img_w); m_h = int'(img_h);
                if (m_w == 0 || m_h == 0 || m_w > 640 || m_h > 480) begin
                    m_w = DEFAULT_W; m_h = DEFAULT_H;
                end
                m_reads = win ? 1 : 0;
            end else if (win) m_reads++;
        end else begin
            model_reset(); win = 0; e_done = 0; e_pix = 0;
        end
        hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = e_pix;
        hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = rst_n ? v : 1'b0;
        @(posedge clk); #1;
        if (mem_rd_en !== win || frame_done !== e_done || (win && mem_addr !== 17'(m_addr)) ||
            (!rst_n && mem_addr !== 17'd0) || pix_out !== 8'(hp[2]) || pix_de !== hd[2]) begin
            if (seg_bad == 0)
                first_bad = $sformatf("(%0d,%0d) rd=%b addr=%0d done=%b pix=%0d de=%b want rd=%b addr=%0d done=%b pix=%0d de=%b",
                    x, y, mem_rd_en, mem_addr, frame_done, pix_out, pix_de, win, m_addr, e_done, hp[2], hd[2]);
            seg_bad++;
        end
        rd_cnt += int'(mem_rd_en);
        done_cnt += int'(frame_done);
    endtask

    task automatic scan(input int xl, input int xh, input int yl, input int yh, input int sw_y);
        for (int y = yl; y <= yh; y++) begin
            if (y == sw_y) begin img_w = 10'(ENLARGED_W); img_h = 9'(ENLARGED_H); end
            for (int x = xl; x <= xh; x++) begin
                cyc(x, y, 1'b1, 1'b0);
                foreach (probes[k]) if (probes[k].x == x && probes[k].y == y) begin
                    check($sformatf("(%0d,%0d) rd", x, y), int'(mem_rd_en), probes[k].rd);
                    check($sformatf("(%0d,%0d) done", x, y), int'(frame_done), probes[k].done);
                    if (probes[k].addr >= 0) check($sformatf("(%0d,%0d) addr", x, y), int'(mem_addr), probes[k].addr);
                    if (probes[k].pix >= 0) check($sformatf("(%0d,%0d) pix", x, y), int'(pix_out), probes[k].pix);
                end
            end
        end
    endtask

    task automatic frame_start(input int w, input int h);
        img_w = 10'(w); img_h = 9'(h);
        cyc(0, 0, 1'b0, 1'b1);
        cyc(0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int r0, d0, x0, y0, x, y;
        model_reset();
        repeat (3) cyc(0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        check("reset addr", int'(mem_addr), 0);
        check("reset rd_en", int'(mem_rd_en), 0);
        check("reset pix", int'(pix_out), 0);
        check("reset de", int'(pix_de), 0);
        check("reset done", int'(frame_done), 0);

        // No frame_start yet: window region scanned but nothing may be read.
        for (int i = 0; i < 300; i++) cyc($urandom_range(230, 410), $urandom_range(170, 310), 1'b1, 1'b0);
        check("pre-FS reads", rd_cnt, 0);
        seg_end("pre-FS border");

        // 160x120 frame, image size switched to 320x240 mid-frame.
        frame_start(DEFAULT_W, DEFAULT_H);
        r0 = rd_cnt; d0 = done_cnt;
        probes = '{'{239,180,0,-1,0,-1}, '{240,180,1,0,0,-1}, '{399,180,1,159,0,-1},
                   '{401,180,0,-1,0,159}, '{240,181,1,160,0,-1}, '{399,299,1,19199,1,-1},
                   '{401,299,0,-1,0,255}, '{240,300,0,-1,0,-1}};
        scan(238, 401, 179, 300, 240);
        check("160x120 reads", rd_cnt - r0, 19200);
        check("160x120 done pulses", done_cnt - d0, 1);
        seg_end("160x120 frame");

        // Next frame runs as 320x240 (first lines only).
        frame_start(int'(img_w), int'(img_h));
        r0 = rd_cnt;
        probes = '{'{159,120,0,-1,0,-1}, '{160,120,1,0,0,-1}, '{479,120,1,319,0,-1},
                   '{481,120,0,-1,0,63}, '{160,121,1,320,0,-1}, '{479,121,1,639,0,-1},
                   '{160,119,0,-1,0,-1}};
        scan(158, 481, 119, 121, -1);
        check("320x240 partial reads", rd_cnt - r0, 640);
        seg_end("320x240 lines");

        frame_start(REDUCED_W, REDUCED_H);
        r0 = rd_cnt; d0 = done_cnt;
        probes = '{'{279,210,0,-1,0,-1}, '{280,210,1,0,0,-1}, '{359,269,1,4799,1,-1},
                   '{361,269,0,-1,0,191}, '{280,209,0,-1,0,-1}};
        scan(278, 361, 209, 270, -1);
        check("80x60 reads", rd_cnt - r0, 4800);
        check("80x60 done pulses", done_cnt - d0, 1);
        seg_end("80x60 frame");

        // Vector table: invalid sizes, extremes, misplaced frame_start.
        vt = '{'{1,0,120,0,0,0,0,-1,0},       '{0,0,120,239,180,1,0,-1,0},
               '{0,0,120,240,180,1,1,0,0},     '{0,0,120,241,180,1,1,1,0},
               '{0,0,120,242,180,0,0,-1,0},    '{1,700,120,0,0,0,0,-1,0},
               '{0,700,120,240,180,1,1,0,0},   '{0,700,120,399,299,1,1,1,1},
               '{0,700,120,400,299,1,0,-1,0},  '{1,160,0,0,0,0,0,-1,0},
               '{0,160,0,240,180,1,1,0,0},     '{1,160,481,0,0,0,0,-1,0},
               '{0,160,481,240,179,1,0,-1,0},  '{0,160,481,240,180,1,1,0,0},
               '{1,640,480,0,0,0,0,-1,0},      '{0,640,480,0,0,1,1,0,0},
               '{0,640,480,639,479,1,1,1,1},   '{0,640,480,640,479,1,0,-1,0},
               '{1,80,60,5,0,1,1,0,0},         '{0,80,60,5,0,1,0,-1,0},
               '{0,80,60,280,210,1,1,-1,0}};
        foreach (vt[i]) begin
            img_w = 10'(vt[i].w); img_h = 9'(vt[i].h);
            cyc(vt[i].x, vt[i].y, vt[i].v, vt[i].f);
            check($sformatf("vec%0d rd", i), int'(mem_rd_en), vt[i].rd);
            check($sformatf("vec%0d done", i), int'(frame_done), vt[i].done);
            if (vt[i].addr >= 0) check($sformatf("vec%0d addr", i), int'(mem_addr), vt[i].addr);
        end
        cyc(0, 0, 1'b0, 1'b0); cyc(0, 0, 1'b0, 1'b0);
        seg_end("vector table");

        // Reset at address 5000 mid-frame.
        frame_start(DEFAULT_W, DEFAULT_H);
        for (int i = 0; i <= 5000; i++) cyc(240 + i % 160, 180 + i / 160, 1'b1, 1'b0);
        check("addr before reset", int'(mem_addr), 5000);
        rst_n = 1'b0;
        #1;
        check("async reset addr", int'(mem_addr), 0);
        check("async reset rd_en", int'(mem_rd_en), 0);
        check("async reset pix", int'(pix_out), 0);
        check("async reset de", int'(pix_de), 0);
        cyc(281, 211, 1'b1, 1'b0); cyc(282, 211, 1'b1, 1'b0);
        rst_n = 1'b1;
        r0 = rd_cnt;
        for (int i = 0; i < 100; i++) cyc(283 + i, 211, 1'b1, 1'b0);
        check("reads after reset w/o FS", rd_cnt - r0, 0);
        frame_start(DEFAULT_W, DEFAULT_H);
        cyc(240, 180, 1'b1, 1'b0);
        check("restart rd", int'(mem_rd_en), 1);
        check("restart addr", int'(mem_addr), 0);
        seg_end("reset mid-frame");

        // Random frames: mixed geometries, random raster points, ignored size changes.
        for (int f = 0; f < 5; f++) begin
            case ($urandom_range(0, 4))
                0: frame_start(REDUCED_W, REDUCED_H);
                1: frame_start(DEFAULT_W, DEFAULT_H);
                2: frame_start(ENLARGED_W, ENLARGED_H);
                3: frame_start($urandom_range(1, 640), $urandom_range(1, 480));
                default: frame_start($urandom_range(641, 1023), $urandom_range(0, 511));
            endcase
            for (int i = 0; i < 1500; i++) begin
                x0 = (640 - m_w) / 2; y0 = (480 - m_h) / 2;
                if ($urandom_range(0, 1) == 1) begin
                    x = x0 - 1 + $urandom_range(0, m_w + 1);
                    y = y0 - 1 + $urandom_range(0, m_h + 1);
                end else begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                end
                if ($urandom_range(0, 99) == 0) begin
                    img_w = 10'($urandom_range(0, 1023)); img_h = 9'($urandom_range(0, 511));
                end
                cyc(x, y, $urandom_range(0, 3) != 0, 1'b0);
            end
            seg_end($sformatf("random frame %0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
